// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-readback traffic generator: writes NUM_BURSTS bursts, reads them back, counts errors.
// Define AXI_TG_PRBS_EN to use a 32-bit LFSR beat pattern instead of the beat-address pattern.
module axi_traffic_gen #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 512,
  parameter int BURST_LEN  = 4,
  parameter int NUM_BURSTS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] s_axi_awaddr,
  output logic [7:0]        s_axi_awlen,
  output logic              s_axi_awvalid,
  input  logic              s_axi_awready,
  output logic [DATA_W-1:0] s_axi_wdata,
  output logic              s_axi_wlast,
  output logic              s_axi_wvalid,
  input  logic              s_axi_wready,
  input  logic [1:0]        s_axi_bresp,
  input  logic              s_axi_bvalid,
  output logic              s_axi_bready,
  output logic [ADDR_W-1:0] s_axi_araddr,
  output logic [7:0]        s_axi_arlen,
  output logic              s_axi_arvalid,
  input  logic              s_axi_arready,
  input  logic [DATA_W-1:0] s_axi_rdata,
  input  logic [1:0]        s_axi_rresp,
  input  logic              s_axi_rlast,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready
);

  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int REPL        = DATA_W / 32;
  localparam int BCNT_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [7:0]        LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAL, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          beat_q, beat_d;
  logic [BCNT_W-1:0]   burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         err_q, err_d;
  logic [31:0]         beat_word;
  logic [DATA_W-1:0]   beat_data;
  logic [1:0]          r_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef AXI_TG_PRBS_EN
  logic [31:0] lfsr_q, lfsr_d;

  // Fibonacci form of x^32 + x^22 + x^2 + x + 1
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  assign beat_word = lfsr_q;
`else
  assign beat_word = 32'(addr_q) + 32'(beat_q) * 32'(BEAT_BYTES);
`endif

  assign beat_data = {REPL{beat_word}};

  // A read beat can cost up to three errors: data, response and rlast placement.
  assign r_inc = 2'(s_axi_rdata != beat_data) + 2'(s_axi_rresp != 2'b00)
               + 2'(s_axi_rlast != (beat_q == LAST_BEAT));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    err_d   = err_q;
`ifdef AXI_TG_PRBS_EN
    lfsr_d  = lfsr_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT_CAL;
          beat_d  = '0;
          burst_d = '0;
          addr_d  = '0;
          err_d   = '0;
        end
      end
      S_WAIT_CAL: begin
        if (init_calib_complete) begin
          state_d = S_AW;
`ifdef AXI_TG_PRBS_EN
          lfsr_d  = 32'h1;
`endif
        end
      end
      S_AW: if (s_axi_awready) state_d = S_W;
      S_W: begin
        if (s_axi_wready) begin
`ifdef AXI_TG_PRBS_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_B: begin
        if (s_axi_bvalid) begin
          if (s_axi_bresp != 2'b00) err_d = sat_add(err_q, 2'd1);
          if (burst_q == LAST_BURST) begin
            burst_d = '0;
            addr_d  = '0;
            state_d = S_AR;
`ifdef AXI_TG_PRBS_EN
            lfsr_d  = 32'h1;
`endif
          end else begin
            burst_d = burst_q + 1'b1;
            addr_d  = addr_q + ADDR_W'(BURST_BYTES);
            state_d = S_AW;
          end
        end
      end
      S_AR: if (s_axi_arready) state_d = S_R;
      S_R: begin
        if (s_axi_rvalid) begin
          err_d = sat_add(err_q, r_inc);
`ifdef AXI_TG_PRBS_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          // The burst ends on the expected last beat whatever rlast says.
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              state_d = S_DONE;
            end else begin
              burst_d = burst_q + 1'b1;
              addr_d  = addr_q + ADDR_W'(BURST_BYTES);
              state_d = S_AR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      err_q   <= '0;
`ifdef AXI_TG_PRBS_EN
      lfsr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef AXI_TG_PRBS_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign err_cnt       = err_q;
  assign s_axi_awaddr  = addr_q;
  assign s_axi_awlen   = LAST_BEAT;
  assign s_axi_awvalid = (state_q == S_AW);
  assign s_axi_wdata   = beat_data;
  assign s_axi_wvalid  = (state_q == S_W);
  assign s_axi_wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
  assign s_axi_bready  = (state_q == S_B);
  assign s_axi_araddr  = addr_q;
  assign s_axi_arlen   = LAST_BEAT;
  assign s_axi_arvalid = (state_q == S_AR);
  assign s_axi_rready  = (state_q == S_R);

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: three parameterisations, each with a small AXI slave memory model.
module tb_axi_traffic_gen;

  localparam int NI = 3;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int NV = 9;

  typedef struct {
    int         inst;
    bit         stall;
    int         flip;
    int         rrb;
    logic [1:0] bresp;
    int         rlm;
    int         e_aw;
    int         e_w;
    int         e_b;
    int         e_ar;
    int         e_r;
    int         e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start [NI];
  logic          clr [NI];
  logic          busy [NI];
  logic          done [NI];
  logic [15:0]   err_cnt [NI];
  logic [AW-1:0] awaddr [NI];
  logic [AW-1:0] araddr [NI];
  logic [7:0]    awlen [NI];
  logic [7:0]    arlen [NI];
  logic          awvalid [NI], awready [NI];
  logic          wlast [NI], wvalid [NI], wready [NI];
  logic          bvalid [NI], bready [NI];
  logic          arvalid [NI], arready [NI];
  logic          rlast [NI], rvalid [NI], rready [NI];
  logic [DW-1:0] wdata [NI];
  logic [DW-1:0] rdata [NI];
  logic [1:0]    bresp [NI];
  logic [1:0]    rresp [NI];

  bit          stall_en [NI];
  int          flip_beat [NI];
  int          rresp_beat [NI];
  logic [1:0]  bresp_cfg [NI];
  int          rl_mode [NI];

  int          n_aw [NI], n_w [NI], n_b [NI], n_ar [NI], n_r [NI], proto_err [NI];
  int unsigned r_last_cyc [NI];

  int nchk = 0;
  int nmiss = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int BL = (g == 1) ? 1 : 4;
    localparam int NB = (g == 0) ? 8 : ((g == 1) ? 3 : 4);

    axi_traffic_gen #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .NUM_BURSTS(NB)) u_dut (
      .clk                 (clk),
      .rst                 (rst),
      .init_calib_complete (calib),
      .start               (start[g]),
      .busy                (busy[g]),
      .done                (done[g]),
      .err_cnt             (err_cnt[g]),
      .s_axi_awaddr        (awaddr[g]),
      .s_axi_awlen         (awlen[g]),
      .s_axi_awvalid       (awvalid[g]),
      .s_axi_awready       (awready[g]),
      .s_axi_wdata         (wdata[g]),
      .s_axi_wlast         (wlast[g]),
      .s_axi_wvalid        (wvalid[g]),
      .s_axi_wready        (wready[g]),
      .s_axi_bresp         (bresp[g]),
      .s_axi_bvalid        (bvalid[g]),
      .s_axi_bready        (bready[g]),
      .s_axi_araddr        (araddr[g]),
      .s_axi_arlen         (arlen[g]),
      .s_axi_arvalid       (arvalid[g]),
      .s_axi_arready       (arready[g]),
      .s_axi_rdata         (rdata[g]),
      .s_axi_rresp         (rresp[g]),
      .s_axi_rlast         (rlast[g]),
      .s_axi_rvalid        (rvalid[g]),
      .s_axi_rready        (rready[g])
    );

    logic [DW-1:0] mem [32];
    int            wbeat, rissued, rtotal;
    logic [AW-1:0] waddr, raddr, aw_hold;
    logic          r_active, aw_stall, w_stall, wl_hold;
    logic [DW-1:0] w_hold;

    logic          aw_hs, w_hs, ar_hs, r_hs, r_free;
    logic          aw_bad, w_bad, ar_bad, aws_bad, ws_bad;
    logic [31:0]   w_exp;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic          r_l;

    assign aw_hs   = awvalid[g] && awready[g];
    assign w_hs    = wvalid[g] && wready[g];
    assign ar_hs   = arvalid[g] && arready[g];
    assign r_hs    = rvalid[g] && rready[g];
    assign r_free  = !rvalid[g] || rready[g];
    assign w_exp   = waddr + 32'(wbeat * 64);
    assign aw_bad  = aw_hs && (awaddr[g] != AW'(n_aw[g] * BL * 64) || awlen[g] != 8'(BL - 1));
    assign ar_bad  = ar_hs && (araddr[g] != AW'(n_ar[g] * BL * 64) || arlen[g] != 8'(BL - 1));
    assign w_bad   = w_hs && (wdata[g] != {(DW / 32){w_exp}} || wlast[g] != (wbeat == BL - 1));
    assign aws_bad = aw_stall && (!awvalid[g] || awaddr[g] != aw_hold);
    assign ws_bad  = w_stall && (!wvalid[g] || wdata[g] != w_hold || wlast[g] != wl_hold);
    assign r_a     = raddr + AW'(rissued * 64);
    assign r_d     = mem[r_a[10:6]] ^ DW'(rtotal == flip_beat[g]);
    assign r_l     = ((rissued == BL - 1) && !(rl_mode[g] == 1 && rtotal == BL - 1))
                   || (rl_mode[g] == 2 && rtotal == 0);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        awready[g] <= 1'b0; wready[g] <= 1'b0; arready[g] <= 1'b0;
        bvalid[g] <= 1'b0; bresp[g] <= 2'b00;
        rvalid[g] <= 1'b0; rdata[g] <= '0; rresp[g] <= 2'b00; rlast[g] <= 1'b0;
        n_aw[g] <= 0; n_w[g] <= 0; n_b[g] <= 0; n_ar[g] <= 0; n_r[g] <= 0;
        proto_err[g] <= 0; r_last_cyc[g] <= 0;
        wbeat <= 0; rissued <= 0; rtotal <= 0; r_active <= 1'b0;
        waddr <= '0; raddr <= '0; aw_hold <= '0; w_hold <= '0; wl_hold <= 1'b0;
        aw_stall <= 1'b0; w_stall <= 1'b0;
      end else if (clr[g]) begin
        n_aw[g] <= 0; n_w[g] <= 0; n_b[g] <= 0; n_ar[g] <= 0; n_r[g] <= 0;
        proto_err[g] <= 0; rtotal <= 0;
      end else begin
        awready[g] <= stall_en[g] ? ($urandom % 2 == 0) : 1'b1;
        wready[g]  <= stall_en[g] ? ($urandom % 2 == 0) : 1'b1;
        arready[g] <= stall_en[g] ? ($urandom % 2 == 0) : 1'b1;
        proto_err[g] <= proto_err[g] + 32'(aw_bad) + 32'(w_bad) + 32'(ar_bad)
                        + 32'(aws_bad) + 32'(ws_bad);
        aw_stall <= awvalid[g] && !awready[g];
        aw_hold  <= awaddr[g];
        w_stall  <= wvalid[g] && !wready[g];
        w_hold   <= wdata[g];
        wl_hold  <= wlast[g];
        if (aw_hs) begin
          n_aw[g] <= n_aw[g] + 1;
          waddr   <= awaddr[g];
          wbeat   <= 0;
        end
        if (w_hs) begin
          mem[w_exp[10:6]] <= wdata[g];
          n_w[g] <= n_w[g] + 1;
          wbeat  <= wbeat + 1;
          if (wbeat == BL - 1) begin
            bvalid[g] <= 1'b1;
            bresp[g]  <= bresp_cfg[g];
          end
        end
        if (bvalid[g] && bready[g]) begin
          bvalid[g] <= 1'b0;
          bresp[g]  <= 2'b00;
          n_b[g]    <= n_b[g] + 1;
        end
        if (ar_hs) begin
          n_ar[g]  <= n_ar[g] + 1;
          raddr    <= araddr[g];
          rissued  <= 0;
          r_active <= 1'b1;
        end
        if (r_hs) begin
          n_r[g]        <= n_r[g] + 1;
          r_last_cyc[g] <= cyc;
        end
        if (r_free) begin
          if (r_active && (!stall_en[g] || ($urandom % 2 == 0))) begin
            rvalid[g] <= 1'b1;
            rdata[g]  <= r_d;
            rresp[g]  <= (rtotal == rresp_beat[g]) ? 2'b10 : 2'b00;
            rlast[g]  <= r_l;
            rissued   <= rissued + 1;
            rtotal    <= rtotal + 1;
            if (rissued == BL - 1) r_active <= 1'b0;
          end else begin
            rvalid[g] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nmiss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input int i, input bit with_clr);
    @(negedge clk);
    start[i] = 1'b1;
    clr[i]   = with_clr;
    @(negedge clk);
    start[i] = 1'b0;
    clr[i]   = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int k;
    k = 0;
    while (!done[i] && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, longint'(done[i]), 1);
    check({tag, " done latency"}, longint'(cyc) - longint'(r_last_cyc[i]), 1);
  endtask

  initial begin
    vec_t  tbl [NV];
    string tag;
    int    i;
    int    k;

    //          inst stall flip rrb bresp  rlm aw  w  b  ar  r  err
    tbl[0] = '{0, 1'b0, -1, -1, 2'b00, 0, 8, 32, 8, 8, 32, 0};
    tbl[1] = '{0, 1'b0,  5, -1, 2'b00, 0, 8, 32, 8, 8, 32, 1};
    tbl[2] = '{1, 1'b1, -1, -1, 2'b00, 0, 3,  3, 3, 3,  3, 0};
    tbl[3] = '{2, 1'b0, -1, -1, 2'b10, 0, 4, 16, 4, 4, 16, 4};
    tbl[4] = '{0, 1'b1,  0, -1, 2'b01, 0, 8, 32, 8, 8, 32, 9};
    tbl[5] = '{0, 1'b0,  5,  5, 2'b00, 0, 8, 32, 8, 8, 32, 2};
    tbl[6] = '{0, 1'b0, -1, -1, 2'b00, 1, 8, 32, 8, 8, 32, 1};
    tbl[7] = '{0, 1'b0, -1, -1, 2'b00, 2, 8, 32, 8, 8, 32, 1};
    tbl[8] = '{2, 1'b1, 15, -1, 2'b11, 0, 4, 16, 4, 4, 16, 5};

    calib = 1'b0;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0; clr[g] = 1'b0; stall_en[g] = 1'b0; flip_beat[g] = -1;
      rresp_beat[g] = -1; bresp_cfg[g] = 2'b00; rl_mode[g] = 0;
    end

    repeat (3) @(negedge clk);
    check("reset busy", longint'(busy[0]), 0);
    check("reset done", longint'(done[0]), 0);
    check("reset err_cnt", longint'(err_cnt[0]), 0);
    check("reset valids", longint'({awvalid[0], wvalid[0], arvalid[0], bready[0], rready[0], wlast[0]}), 0);
    check("reset addrs", longint'(awaddr[0] | araddr[0]), 0);
    check("reset wdata zero", longint'(wdata[0] == '0), 1);
    rst = 1'b0;

    // Calibration hold: the pass must not issue AW until init_calib_complete rises.
    pulse_start(0, 1'b1);
    repeat (10) @(negedge clk);
    check("cal busy", longint'(busy[0]), 1);
    check("cal no aw", longint'(awvalid[0]), 0);
    calib = 1'b1;
    wait_done(0, "cal");
    check("cal aw count", n_aw[0], 8);

    for (int v = 0; v < NV; v++) begin
      i = tbl[v].inst;
      tag = $sformatf("v%0d", v);
      stall_en[i]   = tbl[v].stall;
      flip_beat[i]  = tbl[v].flip;
      rresp_beat[i] = tbl[v].rrb;
      bresp_cfg[i]  = tbl[v].bresp;
      rl_mode[i]    = tbl[v].rlm;
      pulse_start(i, 1'b1);
      check({tag, " busy"}, longint'(busy[i]), 1);
      check({tag, " err clear"}, longint'(err_cnt[i]), 0);
      wait_done(i, tag);
      check({tag, " aw"}, n_aw[i], tbl[v].e_aw);
      check({tag, " w"}, n_w[i], tbl[v].e_w);
      check({tag, " b"}, n_b[i], tbl[v].e_b);
      check({tag, " ar"}, n_ar[i], tbl[v].e_ar);
      check({tag, " r"}, n_r[i], tbl[v].e_r);
      check({tag, " err_cnt"}, longint'(err_cnt[i]), tbl[v].e_err);
      check({tag, " busy low"}, longint'(busy[i]), 0);
      check({tag, " protocol"}, proto_err[i], 0);
      stall_en[i] = 1'b0; flip_beat[i] = -1; rresp_beat[i] = -1;
      bresp_cfg[i] = 2'b00; rl_mode[i] = 0;
    end

    // A second start while busy must not restart the pass.
    pulse_start(0, 1'b1);
    repeat (20) @(negedge clk);
    pulse_start(0, 1'b0);
    wait_done(0, "restart");
    check("restart aw", n_aw[0], 8);
    check("restart r", n_r[0], 32);
    check("restart err_cnt", longint'(err_cnt[0]), 0);

    // Reset while the third W beat of the first burst is on the bus.
    pulse_start(0, 1'b1);
    k = 0;
    while (!(n_w[0] == 2 && wvalid[0]) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("midrst reached beat 2", longint'(n_w[0] == 2 && wvalid[0]), 1);
    rst = 1'b1;
    #1;
    check("midrst valids", longint'({awvalid[0], wvalid[0], arvalid[0], bready[0], rready[0], wlast[0]}), 0);
    check("midrst busy", longint'(busy[0]), 0);
    check("midrst wdata zero", longint'(wdata[0] == '0), 1);
    check("midrst awaddr", longint'(awaddr[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(0, 1'b1);
    wait_done(0, "after rst");
    check("after rst w", n_w[0], 32);
    check("after rst r", n_r[0], 32);
    check("after rst err_cnt", longint'(err_cnt[0]), 0);
    check("after rst protocol", proto_err[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nmiss);
    $finish;
  end

endmodule
